// File: rtl/sn_popcount_stream_if.sv
// rtl/sn_popcount_stream_if.sv - beat input and frame result handshake bundle for sn_popcount_stream
interface sn_popcount_stream_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              approx_en;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic [ACC_W-1:0]  out_err;
    logic              out_sat;

    modport master (
        output in_valid, in_data, in_last, approx_en, out_ready,
        input  in_ready, out_valid, out_count, out_err, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, approx_en, out_ready,
        output in_ready, out_valid, out_count, out_err, out_sat
    );
endinterface

// File: rtl/sn_popcount_stream.sv
// rtl/sn_popcount_stream.sv - streaming frame popcount using exact or approximate sorting-network 4-bit counters
module sn_popcount_stream #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 16
) (
    input logic               clk,
    input logic               rst,
    sn_popcount_stream_if.slave bus
);
    localparam int G     = DATA_W / 4;
    localparam int SUM_W = $clog2(4 * G + 1);
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});

    // 4-input bit sorter: returns {A, h1, h2, D} with A >= h1 >= h2 >= D
    function automatic logic [3:0] sort4(input logic [3:0] x);
        logic [3:0] a;
        logic       m1, m2;
        a  = {x[3] | x[2], x[3] & x[2], x[1] | x[0], x[1] & x[0]};
        m1 = a[3] & a[1];
        m2 = a[2] | a[0];
        return {a[3] | a[1], m1 | m2, m1 & m2, a[2] & a[0]};
    endfunction

    // Counter value of one group; approximate mode reports 4 ones as 3
    function automatic logic [2:0] group_value(input logic [3:0] x, input logic approx);
        logic [3:0] s;
        s = sort4(x);
        if (approx)
            return {1'b0, s[2], (s[3] & ~s[2]) | s[1]};
        else
            return {2'b00, s[3]} + {2'b00, s[2]} + {2'b00, s[1]} + {2'b00, s[0]};
    endfunction

    logic [3*G-1:0]   grp_val;
    logic [G-1:0]     grp_err;
    logic [3*G-1:0]   s1_val;
    logic [G-1:0]     s1_err;
    logic             s1_last;
    logic             s1_valid;
    logic             s1_advance;
    logic [SUM_W-1:0] beat_sum;
    logic [SUM_W-1:0] beat_err;
    logic [ACC_W-1:0] acc_count;
    logic [ACC_W-1:0] acc_err;
    logic             acc_sat;
    logic [EXT_W-1:0] cnt_wide;
    logic [EXT_W-1:0] err_wide;
    logic             cnt_ovf;
    logic             err_ovf;
    logic [ACC_W-1:0] cnt_next;
    logic [ACC_W-1:0] err_next;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_count_q;
    logic [ACC_W-1:0] out_err_q;
    logic             out_sat_q;

    // Per-group counts and error flags of the incoming beat
    always_comb begin
        grp_val = '0;
        grp_err = '0;
        for (int g = 0; g < G; g++) begin
            grp_val[3*g +: 3] = group_value(bus.in_data[4*g +: 4], bus.approx_en);
            grp_err[g]        = bus.approx_en & (&bus.in_data[4*g +: 4]);
        end
    end

    // Beat totals of the group counts held in S1
    always_comb begin
        beat_sum = '0;
        beat_err = '0;
        for (int g = 0; g < G; g++) begin
            beat_sum = beat_sum + SUM_W'(s1_val[3*g +: 3]);
            beat_err = beat_err + SUM_W'(s1_err[g]);
        end
    end

    // Saturating accumulator update, computed one bit wider to detect overflow
    always_comb begin
        cnt_wide = EXT_W'(acc_count) + EXT_W'(beat_sum);
        err_wide = EXT_W'(acc_err) + EXT_W'(beat_err);
        cnt_ovf  = cnt_wide > ACC_MAX;
        err_ovf  = err_wide > ACC_MAX;
        cnt_next = cnt_ovf ? {ACC_W{1'b1}} : cnt_wide[ACC_W-1:0];
        err_next = err_ovf ? {ACC_W{1'b1}} : err_wide[ACC_W-1:0];
    end

    // Only a last beat facing an unconsumed result can hold S1
    assign s1_advance   = s1_valid & ~(s1_last & out_valid_q & ~bus.out_ready);
    assign bus.in_ready = ~s1_valid | s1_advance;

    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_sat   = out_sat_q;

    // S1 capture, frame accumulation and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_val      <= '0;
            s1_err      <= '0;
            s1_last     <= 1'b0;
            s1_valid    <= 1'b0;
            acc_count   <= '0;
            acc_err     <= '0;
            acc_sat     <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_err_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_val  <= grp_val;
                    s1_err  <= grp_err;
                    s1_last <= bus.in_last;
                end
            end

            if (s1_advance && s1_last) begin
                out_count_q <= cnt_next;
                out_err_q   <= err_next;
                out_sat_q   <= acc_sat | cnt_ovf | err_ovf;
                out_valid_q <= 1'b1;
                acc_count   <= '0;
                acc_err     <= '0;
                acc_sat     <= 1'b0;
            end else begin
                if (s1_advance) begin
                    acc_count <= cnt_next;
                    acc_err   <= err_next;
                    acc_sat   <= acc_sat | cnt_ovf | err_ovf;
                end
                if (bus.out_ready)
                    out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sn_popcount_stream.sv
// tb/tb_sn_popcount_stream.sv - self-checking bench for sn_popcount_stream
module tb_sn_popcount_stream;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c;
        int e;
        bit s;
    } res_t;

    res_t q[$];
    int   fc   = 0;
    int   fe   = 0;
    int   npop = 0;

    sn_popcount_stream_if #(.DATA_W(32), .ACC_W(16)) ifa ();
    sn_popcount_stream_if #(.DATA_W(32), .ACC_W(6))  ifb ();

    sn_popcount_stream #(.DATA_W(32), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sn_popcount_stream #(.DATA_W(32), .ACC_W(6))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame model: total ones per group, except approximate groups of four count 3 and one error
    task automatic model_beat(input logic [31:0] d, input logic last, input logic ap);
        logic [3:0] nib;
        for (int g = 0; g < 8; g++) begin
            nib = d[4*g +: 4];
            if (ap && $countones(nib) == 4) begin
                fc += 3;
                fe += 1;
            end else begin
                fc += $countones(nib);
            end
        end
        if (last) begin
            q.push_back('{c: (fc > 65535) ? 65535 : fc,
                          e: (fe > 65535) ? 65535 : fe,
                          s: (fc > 65535) || (fe > 65535)});
            fc = 0;
            fe = 0;
        end
    endtask

    task automatic send_a(input logic [31:0] d, input logic last, input logic ap);
        int n;
        n = 0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = d;
        ifa.in_last   = last;
        ifa.approx_en = ap;
        #1;
        while (!ifa.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("a_accept_bound", n < 50, 1);
        model_beat(d, last, ap);
        @(negedge clk);
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic last, input logic ap);
        int n;
        n = 0;
        ifb.in_valid  = 1'b1;
        ifb.in_data   = d;
        ifb.in_last   = last;
        ifb.approx_en = ap;
        #1;
        while (!ifb.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b_accept_bound", n < 50, 1);
        @(negedge clk);
        ifb.in_valid = 1'b0;
    endtask

    task automatic expect_a(input string name, input int c, input int e, input bit s);
        int n;
        n = 0;
        #2;
        while (!ifa.out_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({name, "_valid"}, ifa.out_valid, 1);
        chk({name, "_count"}, ifa.out_count, c);
        chk({name, "_err"}, ifa.out_err, e);
        chk({name, "_sat"}, ifa.out_sat, s);
    endtask

    task automatic expect_b(input string name, input int c, input int e, input bit s);
        int n;
        n = 0;
        #2;
        while (!ifb.out_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({name, "_valid"}, ifb.out_valid, 1);
        chk({name, "_count"}, ifb.out_count, c);
        chk({name, "_err"}, ifb.out_err, e);
        chk({name, "_sat"}, ifb.out_sat, s);
    endtask

    // Every visible result of dut_a must match the model queue head; pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ifa.out_valid) begin
                if (q.size() == 0) begin
                    chk("model_unexpected_result", 1, 0);
                end else begin
                    chk("model_count", ifa.out_count, q[0].c);
                    chk("model_err", ifa.out_err, q[0].e);
                    chk("model_sat", ifa.out_sat, q[0].s);
                    if (ifa.out_ready) begin
                        void'(q.pop_front());
                        npop++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst           = 1'b1;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_last   = 1'b0;
        ifa.approx_en = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0;
        ifb.in_data   = '0;
        ifb.in_last   = 1'b0;
        ifb.approx_en = 1'b0;
        ifb.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_count", ifa.out_count, 0);
        chk("rst_out_err", ifa.out_err, 0);
        chk("rst_out_sat", ifa.out_sat, 0);
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_b_out_valid", ifb.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Exact all-ones single beat, with two-edge latency
        send_a(32'hFFFF_FFFF, 1'b1, 1'b0);
        #2;
        chk("t1_not_yet_valid", ifa.out_valid, 0);
        @(negedge clk);
        #2;
        chk("t1_valid", ifa.out_valid, 1);
        chk("t1_count", ifa.out_count, 32);
        chk("t1_err", ifa.out_err, 0);
        chk("t1_sat", ifa.out_sat, 0);
        @(negedge clk);

        // Approximate all-ones, then approx/exact two-beat frame
        send_a(32'hFFFF_FFFF, 1'b1, 1'b1);
        expect_a("t2a", 24, 8, 1'b0);
        @(negedge clk);
        send_a(32'h0000_0007, 1'b0, 1'b1);
        send_a(32'h1111_1111, 1'b1, 1'b0);
        expect_a("t2b", 11, 0, 1'b0);
        @(negedge clk);

        // Mixed mode frame
        send_a(32'hF000_000F, 1'b0, 1'b1);
        send_a(32'hF000_0000, 1'b0, 1'b0);
        send_a(32'h0000_00FF, 1'b1, 1'b1);
        expect_a("t3", 16, 4, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Backpressure on back-to-back single-beat frames
        ifa.out_ready = 1'b0;
        p0 = npop;
        fork
            begin
                send_a(32'h0000_0001, 1'b1, 1'b0);
                send_a(32'h0000_0003, 1'b1, 1'b0);
                send_a(32'h0000_0007, 1'b1, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("t4_stall_in_ready", ifa.in_ready, 0);
                chk("t4_hold_valid", ifa.out_valid, 1);
                chk("t4_hold_count", ifa.out_count, 1);
                ifa.out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("t4_results_emitted", npop - p0, 3);
        chk("t4_queue_drained", q.size(), 0);

        // Saturation on the narrow instance
        send_b(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_b(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_b(32'hFFFF_FFFF, 1'b1, 1'b0);
        expect_b("t5a", 63, 0, 1'b1);
        @(negedge clk);
        send_b(32'h0000_0001, 1'b1, 1'b0);
        expect_b("t5b", 1, 0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            send_b(32'hFFFF_FFFF, (i == 7), 1'b1);
        expect_b("t5c", 63, 63, 1'b1);
        @(negedge clk);

        // Asynchronous reset mid-frame with a result pending
        ifa.out_ready = 1'b0;
        send_a(32'h0000_0001, 1'b1, 1'b0);
        send_a(32'h0000_00FF, 1'b0, 1'b0);
        #2;
        chk("t6_pending_valid", ifa.out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", ifa.out_valid, 0);
        chk("t6_rst_out_count", ifa.out_count, 0);
        chk("t6_rst_in_ready", ifa.in_ready, 1);
        q.delete();
        fc = 0;
        fe = 0;
        @(negedge clk);
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        send_a(32'h0000_0003, 1'b1, 1'b0);
        expect_a("t6", 2, 0, 1'b0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sn_popcount_stream.md
Name: sn_popcount_stream

Overview:
- Streaming population counter built on the sorting-network 4-bit counter.
- Each input beat is split into 4-bit groups. Each group is counted by a 4-input sorting network, either exactly or approximately.
- Group counts are summed per beat and accumulated across a frame delimited by `in_last`. Results are delivered on a valid/ready output.
- Used as the reduction back-end for approximate multi-operand compressor experiments. Approximate mode reproduces the sorting-network 4:2 approximate counter (count 4 reported as 3) and tracks the error it introduces.

Parameters:
- `DATA_W`, 32: beat width in bits. Must be a multiple of 4 and ≥ 4. G = DATA_W/4 groups.
- `ACC_W`, 16: width of the count/error accumulators and outputs. Must be ≥ 4.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: beat valid.
- `in_ready`, output, 1: beat accepted when `in_valid` and `in_ready` are both 1 at a rising edge.
- `in_data`, input, DATA_W: beat bits. Group g = `in_data[4g+3:4g]`.
- `in_last`, input, 1: last beat of the frame.
- `approx_en`, input, 1: counting mode for this beat. 1 = approximate, 0 = exact.
- `out_valid`, output, 1: frame result valid.
- `out_ready`, input, 1: result consumed when `out_valid` and `out_ready` are both 1 at a rising edge.
- `out_count`, output, ACC_W: frame population count, exact or approximate per beat.
- `out_err`, output, ACC_W: number of groups in the frame that lost a count due to approximation.
- `out_sat`, output, 1: `out_count` or `out_err` saturated during the frame.

Behaviour:
- **Group counter.** Sort the 4 bits (A ≥ h1 ≥ h2 ≥ D), with c = number of ones.
  - Exact mode: value = c (0..4).
  - Approx mode: carry = h1, sum = (A & ~h1) | h2, value = 2·carry + sum. This gives c for c ≤ 3 and 3 for c = 4.
  - Group error = 1 iff approx mode and c = 4, else 0.
- **Stage S1** (registered on accept):
  - Per-group values and per-group error bits.
  - `s1_last`, `s1_valid`.
  - `approx_en` is sampled per beat and applies to that beat only.
- **Stage S2** (accumulate):
  - beat_sum = Σ group values (width ≥ clog2(4G+1)); beat_err = Σ error bits.
  - `acc_count` and `acc_err` add these with saturation at 2^ACC_W−1. Any saturation sets the sticky `acc_sat`.
- **Frame end.** When S1 holds a last beat and advances:
  - `out_count` ← sat(`acc_count` + beat_sum), `out_err` ← sat(`acc_err` + beat_err), `out_sat` ← `acc_sat` or new saturation.
  - `out_valid` ← 1.
  - Accumulators and `acc_sat` clear to 0 in the same edge.
- **Advance rule.**
  - S1 advances unless `s1_last` and `out_valid` and !`out_ready`.
  - `in_ready` = !`s1_valid` | s1_advance (combinational).
  - Non-last beats never stall.
- **Throughput and latency.**
  - Throughput is 1 beat/cycle.
  - A last beat accepted at edge k gives `out_valid` = 1 after edge k+1 (2-cycle latency).
- **Output register.**
  - `out_*` hold while `out_valid` is 1 and `out_ready` is 0.
  - If the result is consumed and a new result is loaded at the same edge, the new result loads and `out_valid` stays 1.
  - If consumed with no new result, `out_valid` ← 0.
- **Framing.** Every frame has ≥ 1 beat. A beat with `in_last` = 1 alone is a single-beat frame.
- **Reset** (asynchronous, any time, including mid-frame or with result pending):
  - `s1_valid`, `out_valid`, `out_sat` = 0; `out_count`, `out_err` = 0; accumulators and `acc_sat` = 0.
  - Any partial frame is discarded.
  - `in_ready` = 1 while out of reset with the pipeline empty.

Test Plan (DATA_W=32, ACC_W=16 unless stated):
1. Exact mode, single beat 0xFFFFFFFF, `last` = 1 → after 2 cycles `out_count` = 32, `out_err` = 0, `out_sat` = 0.
2. Approx mode, same beat → `out_count` = 24, `out_err` = 8. Approx beat 0x00000007 then exact 0x11111111 with `last` = 1 → `out_count` = 11, `out_err` = 0.
3. Mixed frame: approx 0xF000000F, exact 0xF0000000, approx 0x000000FF with `last` = 1 → `out_count` = 6 + 4 + 6 = 16, `out_err` = 4.
4. Backpressure: `out_ready` = 0, back-to-back single-beat frames 0x1, 0x3, 0x7 (exact).
   - Result 1 is held; the second last beat stalls in S1 and `in_ready` = 0.
   - Raise `out_ready` → results emitted in order 1, 2, 3, with no loss or duplication.
5. Saturation, ACC_W=6: three exact beats 0xFFFFFFFF, `last` on the third → `out_count` = 63, `out_sat` = 1. Next frame single beat 0x1 → `out_count` = 1, `out_sat` = 0.
6. Reset mid-frame: accept beat 0xFF (no last), assert `rst` asynchronously → `out_valid` drops immediately. Then single beat 0x3 with `last` = 1 → `out_count` = 2.
